// File: rtl/fmc_led_pkg.sv
// ----------------------------------------------------------------------------
// fmc_led_pkg
//   Shared types and constants for the FMC board LED controller.
//   - mode_e       : display mode encoding (COUNT, RAW, XOR, LAMP)
//   - LAMP_PATTERN : LED pattern shown in LAMP mode
//   - KEY_*        : which front-panel key does what
//   - mode_step    : helper returning the next mode when stepping up or down
// ----------------------------------------------------------------------------
package fmc_led_pkg;

  typedef enum logic [1:0] {
    COUNT = 2'd0,
    RAW   = 2'd1,
    XOR   = 2'd2,
    LAMP  = 2'd3
  } mode_e;

  localparam logic [7:0] LAMP_PATTERN = 8'hFF;

  localparam int KEY_NEXT = 1;
  localparam int KEY_PREV = 2;
  localparam int KEY_DIM  = 3;

  // Step the mode up or down by one, wrapping naturally in two bits.
  function automatic mode_e mode_step(input mode_e cur, input logic up);
    logic [1:0] raw_val;
    if (up) begin
      raw_val = cur + 2'd1;
    end else begin
      raw_val = cur - 2'd1;
    end
    return mode_e'(raw_val);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// ----------------------------------------------------------------------------
// key_debounce
//   One front-panel key: 2-FF synchronizer, level debouncer and falling-edge
//   (press) pulse. Keys are active-low, so the synchronizer idles at 1.
// Parameters
//   DB_CYCLES : consecutive differing synchronized samples needed before the
//               debounced level follows the pin
// Ports
//   clk   in  board clock
//   rst_n in  asynchronous active-low reset
//   raw   in  raw key pin, asynchronous to clk
//   level out debounced key level (registered)
//   fall  out one-cycle pulse in the cycle level goes 1->0 (registered)
// ----------------------------------------------------------------------------
module key_debounce #(
  parameter int DB_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic fall
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic          fall_r;
  logic [CW-1:0] cnt_r;

  // Two-stage synchronizer for the asynchronous key pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
    end
  end

  // Debounce counter; any sample equal to the accepted level restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= '0;
      level_r <= 1'b1;
      fall_r  <= 1'b0;
    end else begin
      fall_r <= 1'b0;
      if (sync2_r == level_r) begin
        cnt_r <= '0;
      end else if (cnt_r == CNT_LAST) begin
        // Accepting a new level: a 1->0 change is a press.
        level_r <= sync2_r;
        cnt_r   <= '0;
        fall_r  <= ~sync2_r;
      end else begin
        cnt_r <= cnt_r + CW'(1'b1);
      end
    end
  end

  assign level = level_r;
  assign fall  = fall_r;

endmodule

// File: rtl/led_mode_ctrl.sv
// ----------------------------------------------------------------------------
// led_mode_ctrl
//   FMC board LED bank controller. Debounces the four front-panel keys, runs a
//   display-mode FSM stepped by key 1 (next) and key 2 (previous), and drives a
//   registered LED pattern chosen by the mode.
//   Optional build macro LED_PWM_EN adds a PWM brightness stage whose duty is
//   stepped by key 3; without it key 3 is ignored. Ports are the same in both.
// Parameters
//   DB_CYCLES : debounce length in clk cycles
//   HB_BITS   : heartbeat counter width (>= 8); COUNT mode shows its top byte
//   PWM_BITS  : PWM counter/duty width (only meaningful with LED_PWM_EN)
// Ports
//   clk      in  board clock
//   rst_n    in  asynchronous active-low reset
//   key      in  raw keys, active-low, asynchronous
//   switch   in  raw DIP switches, asynchronous
//   led      out LED drive, 1 = lit (registered)
//   mode     out current display mode
//   key_db   out debounced key levels, active-low
//   mode_chg out one-cycle pulse in the cycle mode takes a new value
// ----------------------------------------------------------------------------
module led_mode_ctrl
  import fmc_led_pkg::*;
#(
  parameter int DB_CYCLES = 250000,
  parameter int HB_BITS   = 32,
  parameter int PWM_BITS  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key,
  input  logic [3:0] switch,
  output logic [7:0] led,
  output logic [1:0] mode,
  output logic [3:0] key_db,
  output logic       mode_chg
);

  logic [3:0]         key_db_s;
  logic [3:0]         press_s;
  logic [3:0]         sw_sync1_r;
  logic [3:0]         sw_sync2_r;
  logic [HB_BITS-1:0] hb_r;
  mode_e              mode_r;
  mode_e              mode_next_s;
  logic               chg_next_s;
  logic               mode_chg_r;
  logic [7:0]         led_src_s;
  logic [7:0]         led_r;
  logic               pwm_on_s;

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (key[i]),
      .level(key_db_s[i]),
      .fall (press_s[i])
    );
  end

  // Two-stage synchronizer for the DIP switches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_sync1_r <= 4'h0;
      sw_sync2_r <= 4'h0;
    end else begin
      sw_sync1_r <= switch;
      sw_sync2_r <= sw_sync1_r;
    end
  end

  // Free-running heartbeat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb_r <= '0;
    end else begin
      hb_r <= hb_r + HB_BITS'(1'b1);
    end
  end

  // Mode FSM next state: simultaneous next+prev presses cancel out.
  always_comb begin
    mode_next_s = mode_r;
    chg_next_s  = 1'b0;
    case ({press_s[KEY_NEXT], press_s[KEY_PREV]})
      2'b10: begin
        mode_next_s = mode_step(mode_r, 1'b1);
        chg_next_s  = 1'b1;
      end
      2'b01: begin
        mode_next_s = mode_step(mode_r, 1'b0);
        chg_next_s  = 1'b1;
      end
      default: begin
        mode_next_s = mode_r;
        chg_next_s  = 1'b0;
      end
    endcase
  end

  // Mode FSM state register and its change pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r     <= COUNT;
      mode_chg_r <= 1'b0;
    end else begin
      mode_r     <= mode_next_s;
      mode_chg_r <= chg_next_s;
    end
  end

  // LED source selection for the current mode.
  always_comb begin
    led_src_s = 8'h00;
    case (mode_r)
      COUNT:   led_src_s = hb_r[HB_BITS-1 -: 8];
      RAW:     led_src_s = {sw_sync2_r, key_db_s};
      XOR:     led_src_s = {sw_sync2_r ^ key_db_s, sw_sync2_r ^ key_db_s};
      LAMP:    led_src_s = LAMP_PATTERN;
      default: led_src_s = 8'h00;
    endcase
  end

`ifdef LED_PWM_EN
  logic [PWM_BITS-1:0] pwm_cnt_r;
  logic [PWM_BITS-1:0] duty_r;
  logic                unused_ok;

  // PWM phase counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_r <= '0;
    end else begin
      pwm_cnt_r <= pwm_cnt_r + PWM_BITS'(1'b1);
    end
  end

  // Duty register: starts at full brightness, key 3 steps it with wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_r <= '1;
    end else if (press_s[KEY_DIM]) begin
      duty_r <= duty_r + PWM_BITS'(1'b1);
    end else begin
      duty_r <= duty_r;
    end
  end

  // "<=" means duty 0 still lights one slot per period, so never fully dark.
  assign pwm_on_s  = (pwm_cnt_r <= duty_r);
  assign unused_ok = press_s[0];
`else
  logic unused_ok;

  assign pwm_on_s  = 1'b1;
  assign unused_ok = ^{press_s[0], press_s[KEY_DIM], 32'(PWM_BITS)};
`endif

  // Output LED register (optionally gated by the PWM phase).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_r <= 8'h00;
    end else begin
      led_r <= led_src_s & {8{pwm_on_s}};
    end
  end

  assign led      = led_r;
  assign mode     = mode_r;
  assign key_db   = key_db_s;
  assign mode_chg = mode_chg_r;

endmodule
